serial_deser_rx: RTL and testbench

//  Receive-side deserializer for the LSB-first serial stream that the team's
//  N-bit right-shift transmit register produces on its shift-out pin.
//  - Shifts serial bits in on each enabled clock and counts them.
//  - Presents each completed N-bit word on a holding register with a valid/ready handshake.
//  - Flags overrun when a word completes while the previous one is still unconsumed.

---
 rtl/serial_deser_rx.sv | 126 ++++++++++++
 tb/tb_serial_deser_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser_rx.sv
// Receive deserializer for an LSB-first serial stream: assembles N-bit words,
// hands them off through a valid/ready holding register and flags overrun.
module serial_deser_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         SI,
    input  logic         start,
    input  logic         ready,
    input  logic         clr_ovr,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         overrun,
    output logic         busy
);

    localparam int              CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_sh;
    logic [N-1:0]    w_sh_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [N-1:0]    r_q;
    logic            r_valid;
    logic            r_ovr;
    logic [N-1:0]    w_cand;
    logic            w_done;
    logic            w_load;
    logic            w_drop;

    // The shifted value doubles as the completed word on the last bit.
    assign w_cand = {SI, r_sh[N-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            HUNT: begin
                if (start) begin
                    w_state_nxt = RECV;
                    w_cnt_nxt   = '0;
                    if (en) begin
                        w_sh_nxt  = w_cand;
                        w_cnt_nxt = ONE;
                    end
                end
            end
            RECV: begin
                // A start re-aligns even on what would have been the last bit.
                if (start) begin
                    w_cnt_nxt = '0;
                    if (en) begin
                        w_sh_nxt  = w_cand;
                        w_cnt_nxt = ONE;
                    end
                end else if (en) begin
                    w_sh_nxt = w_cand;
                    if (r_cnt == LAST) begin
                        w_cnt_nxt = '0;
                        w_done    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_load = w_done && (!r_valid || ready);
    assign w_drop = w_done && r_valid && !ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_q     <= w_cand;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign q       = r_q;
    assign valid   = r_valid;
    assign overrun = r_ovr;
    assign busy    = (r_state == RECV) && (r_cnt != '0);

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx (N=4): directed scenarios plus a random run,
// all compared against a bit-list reference model of the receiver.
module tb_serial_deser_rx;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         SI;
  logic         start;
  logic         ready;
  logic         clr_ovr;
  logic [N-1:0] q;
  logic         valid;
  logic         overrun;
  logic         busy;

  int n_tests;
  int n_fail;

  // reference model state
  bit     m_aligned;
  int     m_idx;
  int     m_bits[N];
  int     m_q;
  bit     m_valid;
  bit     m_ovr;

  serial_deser_rx #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .SI(SI), .start(start), .ready(ready),
    .clr_ovr(clr_ovr), .q(q), .valid(valid), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N+2:0] model_out();
    logic [N-1:0] mq;
    mq = N'(m_q);
    return {mq, m_valid, m_ovr, (m_aligned && m_idx != 0)};
  endfunction

  task automatic model_reset();
    m_aligned = 0; m_idx = 0; m_q = 0; m_valid = 0; m_ovr = 0;
    for (int i = 0; i < N; i++) m_bits[i] = 0;
  endtask

  // One clock edge of the receiver, described as "collect bits into a list".
  task automatic model_edge(input bit e, input bit s, input bit st, input bit rd, input bit cl);
    bit done;
    int word;
    done = 0;
    word = 0;
    if (st) begin
      m_aligned = 1;
      m_idx = 0;
      if (e) begin m_bits[0] = s; m_idx = 1; end
    end else if (m_aligned && e) begin
      m_bits[m_idx] = s;
      m_idx++;
      if (m_idx == N) begin
        for (int i = 0; i < N; i++) word += m_bits[i] * (1 << i);
        m_idx = 0;
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || rd) begin m_q = word; m_valid = 1; end
      else m_ovr = 1;
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
    if (!(done && m_valid && !rd && m_q != word) && cl && !(done && !(m_valid && m_q == word && rd) && m_ovr && 0))
      ;
    if (cl && !(done && m_ovr_set_pending(done, rd))) m_ovr = 0;
  endtask

  // True when this edge's completion was a drop (set beats clear).
  bit m_drop_flag;
  function automatic bit m_ovr_set_pending(input bit done, input bit rd);
    return m_drop_flag;
  endfunction

  task automatic step(input bit e, input bit s, input bit st, input bit rd, input bit cl);
    en = e; SI = s; start = st; ready = rd; clr_ovr = cl;
    // decide drop before the model updates valid
    m_drop_flag = m_aligned && e && !st && (m_idx == N - 1) && m_valid && !rd;
    @(posedge clk);
    model_edge(e, s, st, rd, cl);
    #1;
  endtask

  task automatic do_reset();
    en = 0; SI = 0; start = 0; ready = 0; clr_ovr = 0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit with_start, input bit rd);
    for (int i = 0; i < N; i++) step(1, w[i], with_start && i == 0, rd, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 0; SI = 0; start = 0; ready = 0; clr_ovr = 0;
    model_reset();
    #3;
    n_tests++;
    if ({q, valid, overrun, busy} !== {(N+3){1'b0}}) begin
      $display("FAIL reset_outputs: got q=%h v=%b o=%b b=%b want all 0", q, valid, overrun, busy);
      n_fail++;
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      $display("FAIL basic_busy_mid: got %b want 1", busy); n_fail++;
    end
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_tests++;
    if ({q, valid, overrun, busy} !== {4'hD, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL basic_word: got q=%h v=%b o=%b b=%b want q=d v=1 o=0 b=0", q, valid, overrun, busy);
      n_fail++;
    end
  endtask

  task automatic test_hunt();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL hunt_ignore: got v=%b b=%b want v=0 b=0", valid, busy); n_fail++;
    end
    send_word(4'h2, 1, 0);
    n_tests++;
    if (q !== 4'h2 || valid !== 1'b1) begin
      $display("FAIL hunt_then_start: got q=%h v=%b want q=2 v=1", q, valid); n_fail++;
    end
  endtask

  task automatic test_gaps();
    logic [3:0] w;
    w = 4'hB;
    do_reset();
    for (int i = 0; i < N; i++) begin
      step(1, w[i], i == 0, 0, 0);
      if (i != N - 1) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) step(0, $urandom_range(0, 1), 0, 0, 0);
      end
    end
    n_tests++;
    if ({q, valid, overrun} !== {4'hB, 1'b1, 1'b0}) begin
      $display("FAIL gaps_word: got q=%h v=%b o=%b want q=b v=1 o=0", q, valid, overrun); n_fail++;
    end
    n_tests++;
    if ({q, valid, overrun, busy} !== model_out()) begin
      $display("FAIL gaps_model: got %h want %h", {q, valid, overrun, busy}, model_out()); n_fail++;
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(4'h5, 1, 0);
    send_word(4'hA, 0, 0);
    n_tests++;
    if ({q, valid, overrun} !== {4'h5, 1'b1, 1'b1}) begin
      $display("FAIL ovr_set: got q=%h v=%b o=%b want q=5 v=1 o=1", q, valid, overrun); n_fail++;
    end
    step(0, 0, 0, 0, 1);
    n_tests++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      $display("FAIL ovr_clear: got o=%b v=%b want o=0 v=1", overrun, valid); n_fail++;
    end
    step(0, 0, 0, 1, 0);
    n_tests++;
    if (valid !== 1'b0 || q !== 4'h5) begin
      $display("FAIL ovr_consume: got v=%b q=%h want v=0 q=5", valid, q); n_fail++;
    end
    // set and clear on the same edge: set wins
    send_word(4'h1, 0, 0);
    send_word(4'h7, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < N - 1; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    n_tests++;
    if (overrun !== 1'b1 || q !== 4'h1) begin
      $display("FAIL ovr_set_wins: got o=%b q=%h want o=1 q=1", overrun, q); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int vcnt;
    logic [3:0] w3, wc;
    w3 = 4'h3; wc = 4'hC;
    vcnt = 0;
    do_reset();
    for (int i = 0; i < 2 * N; i++) begin
      step(1, (i < N) ? w3[i] : wc[i - N], i == 0, 1, 0);
      if (valid) vcnt++;
      if (i == N - 1) begin
        n_tests++;
        if (q !== 4'h3 || valid !== 1'b1) begin
          $display("FAIL b2b_first: got q=%h v=%b want q=3 v=1", q, valid); n_fail++;
        end
      end
    end
    step(0, 0, 0, 1, 0);
    if (valid) vcnt++;
    n_tests++;
    if (vcnt != 2 || q !== 4'hC || overrun !== 1'b0) begin
      $display("FAIL b2b_stream: got vcycles=%0d q=%h o=%b want vcycles=2 q=c o=0", vcnt, q, overrun);
      n_fail++;
    end
    send_word(4'h6, 0, 0);
    for (int i = 0; i < N; i++) step(1, (i == 0 || i == 3), 0, i == N - 1, 0);
    n_tests++;
    if ({q, valid, overrun} !== {4'h9, 1'b1, 1'b0}) begin
      $display("FAIL b2b_load_on_ready: got q=%h v=%b o=%b want q=9 v=1 o=0", q, valid, overrun);
      n_fail++;
    end
  endtask

  task automatic test_restart();
    do_reset();
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      $display("FAIL restart_busy: got %b want 1", busy); n_fail++;
    end
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_tests++;
    if ({q, valid} !== {4'h9, 1'b1}) begin
      $display("FAIL restart_word: got q=%h v=%b want q=9 v=1", q, valid); n_fail++;
    end
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({q, valid, overrun, busy} !== {(N+3){1'b0}}) begin
      $display("FAIL async_reset: got q=%h v=%b o=%b b=%b want all 0", q, valid, overrun, busy);
      n_fail++;
    end
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < N; i++) step(1, 1, 0, 0, 0);
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_to_hunt: got v=%b b=%b want v=0 b=0", valid, busy); n_fail++;
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    step(0, 0, 1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      n_tests++;
      if ({q, valid, overrun, busy} !== model_out()) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL random_cycle%0d: got q=%h v=%b o=%b b=%b want %h", c, q, valid, overrun, busy,
                   model_out());
        bad++;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_drop_flag = 0;
    test_reset();
    test_basic();
    test_hunt();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
